// File: rtl/cmd_defs.sv
// Shared definitions for the command-line PHY: FSM state encoding, frame lengths, CRC7 polynomial.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cmd_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_RECEIVE   = 3'd3,
        ST_DONE      = 3'd4
    } cmd_state_t;

    localparam int CMD_BITS        = 40;   // start + transmission + index[5:0] + argument[31:0]
    localparam int SHORT_FRAME_LEN = 48;
    localparam int LONG_FRAME_LEN  = 136;
    localparam int LONG_CRC_SKIP   = 8;    // long frames: start, transmission, 6 reserved bits precede the CRC span

    // x^7 + x^3 + 1 with the x^7 term implicit in the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Index of the last frame bit counted from the start bit (start bit = 0).
    function automatic logic [7:0] frame_last_idx(input logic is_long);
        return is_long ? 8'(LONG_FRAME_LEN - 1) : 8'(SHORT_FRAME_LEN - 1);
    endfunction

endpackage

// File: rtl/crc7.sv
// Serial CRC7 accumulator (x^7+x^3+1, zero seed), one data bit per enabled cycle.
// Latency: remainder reflects a bit on the cycle after it is presented with enable=1.
// Backpressure: none; clear has priority over enable.
//
// Ports: clock/reset (async active-low), clear (zero the remainder), enable + data_bit
//        (absorb one message bit MSB first), remainder (current 7-bit CRC).
module crc7
    import cmd_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] remainder
);

    logic feedback;

    assign feedback = data_bit ^ remainder[6];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remainder <= '0;
        end else if (clear) begin
            remainder <= '0;
        end else if (enable) begin
            remainder <= {remainder[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'd0);
        end
    end

endmodule

// File: rtl/cmd_physical.sv
// Command-line PHY: serialises a 40-bit command with CRC7, then captures a 48/136-bit response.
// Latency: ack_out 1 cycle after strobe_in; 48 send cycles; response wait up to TIMEOUT_CYCLES.
// Backpressure: response held with strobe_out=1 until ack_in; strobe_in ignored unless IDLE.
//
// Ports: clock, reset (async active-low); strobe_in/cmd_to_send/long_response capture a command,
//        ack_out confirms capture; cmd_pin_out/cmd_pin_oe drive the CMD line, cmd_pin_in reads it;
//        strobe_out/response/time_out/crc_error report the result until ack_in; idle_in aborts.
// Build option: define CMD_CRC_CHECK_EN to check the received CRC7 (otherwise crc_error is 0).
module cmd_physical
    import cmd_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic         ack_in,
    input  logic         idle_in,
    input  logic [39:0]  cmd_to_send,
    input  logic         long_response,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_pin_oe,
    output logic         ack_out,
    output logic         strobe_out,
    output logic [127:0] response,
    output logic         time_out,
    output logic         crc_error
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    cmd_state_t         state, state_nxt;
    logic [39:0]        cmd_sr;      // shifts left; bit 39 is the bit on the line
    logic               long_q;
    logic [7:0]         bit_cnt;     // SEND: bit index; RECEIVE: frame bits received so far
    logic [WAIT_W-1:0]  wait_cnt;
    logic [134:0]       frame_sr;
    logic [135:0]       frame_nxt;
    logic [127:0]       resp_q;
    logic               ack_q;
    logic               time_out_q;

    logic               send_last;
    logic               wait_expire;
    logic               rx_last;
    logic               crc_clear;
    logic [6:0]         tx_rem;
    logic [2:0]         tx_crc_idx;

    assign frame_nxt   = {frame_sr, cmd_pin_in};
    assign send_last   = (bit_cnt == 8'(SHORT_FRAME_LEN - 1));
    assign wait_expire = (wait_cnt == WAIT_LAST);
    assign rx_last     = (bit_cnt == frame_last_idx(long_q));
    assign crc_clear   = (state == ST_IDLE) || idle_in;
    // Frame bits 7..1 carry the CRC, MSB of the remainder first.
    assign tx_crc_idx  = 3'(8'(SHORT_FRAME_LEN - 2) - bit_cnt);

    crc7 u_tx_crc (
        .clock     (clock),
        .reset     (reset),
        .clear     (crc_clear),
        .enable    ((state == ST_SEND) && (bit_cnt < 8'(CMD_BITS))),
        .data_bit  (cmd_sr[39]),
        .remainder (tx_rem)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (idle_in) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (strobe_in) state_nxt = ST_SEND;
                ST_SEND:      if (send_last) state_nxt = ST_WAIT_RESP;
                // A start bit on the expiry cycle still wins over the timeout.
                ST_WAIT_RESP: if (!cmd_pin_in)     state_nxt = ST_RECEIVE;
                              else if (wait_expire) state_nxt = ST_DONE;
                ST_RECEIVE:   if (rx_last) state_nxt = ST_DONE;
                ST_DONE:      if (ack_in)  state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_pin_out = 1'b1;
        cmd_pin_oe  = 1'b0;
        strobe_out  = 1'b0;
        case (state)
            ST_SEND: begin
                cmd_pin_oe = 1'b1;
                if (bit_cnt < 8'(CMD_BITS)) begin
                    cmd_pin_out = cmd_sr[39];
                end else if (!send_last) begin
                    cmd_pin_out = tx_rem[tx_crc_idx];
                end
            end
            ST_DONE: strobe_out = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_sr     <= '0;
            long_q     <= 1'b0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            frame_sr   <= '0;
            resp_q     <= '0;
            ack_q      <= 1'b0;
            time_out_q <= 1'b0;
        end else if (idle_in) begin
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            ack_q      <= 1'b0;
            time_out_q <= 1'b0;
        end else begin
            ack_q <= (state == ST_IDLE) && strobe_in;
            case (state)
                ST_IDLE: begin
                    if (strobe_in) begin
                        cmd_sr  <= cmd_to_send;
                        long_q  <= long_response;
                        bit_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    cmd_sr <= {cmd_sr[38:0], 1'b0};
                    if (send_last) begin
                        bit_cnt  <= '0;
                        wait_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                ST_WAIT_RESP: begin
                    if (!cmd_pin_in) begin
                        frame_sr <= frame_nxt[134:0];
                        bit_cnt  <= 8'd1;        // start bit already taken
                    end else if (wait_expire) begin
                        time_out_q <= 1'b1;
                        resp_q     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_RECEIVE: begin
                    frame_sr <= frame_nxt[134:0];
                    bit_cnt  <= bit_cnt + 8'd1;
                    if (rx_last) begin
                        resp_q <= long_q ? frame_nxt[135:8] : {88'd0, frame_nxt[47:8]};
                    end
                end
                ST_DONE: begin
                    if (ack_in) time_out_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CMD_CRC_CHECK_EN
    logic [6:0] rx_rem;
    logic       rx_crc_en;
    logic       crc_err_q;

    // Short frames cover the start bit onward; long frames skip the first 8 bits.
    // bit_cnt is the count already received, so the arriving bit is frame index last-bit_cnt.
    assign rx_crc_en = ((state == ST_WAIT_RESP) && !cmd_pin_in && !long_q) ||
                       ((state == ST_RECEIVE) &&
                        (bit_cnt <= frame_last_idx(long_q) - 8'd8) &&
                        (!long_q || (bit_cnt >= 8'(LONG_CRC_SKIP))));

    crc7 u_rx_crc (
        .clock     (clock),
        .reset     (reset),
        .clear     (crc_clear),
        .enable    (rx_crc_en),
        .data_bit  (cmd_pin_in),
        .remainder (rx_rem)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_err_q <= 1'b0;
        end else if (idle_in) begin
            crc_err_q <= 1'b0;
        end else if ((state == ST_RECEIVE) && rx_last) begin
            crc_err_q <= (rx_rem != frame_nxt[7:1]);
        end else if ((state == ST_DONE) && ack_in) begin
            crc_err_q <= 1'b0;
        end
    end

    assign crc_error = crc_err_q;
`else
    assign crc_error = 1'b0;
`endif

    assign ack_out  = ack_q;
    assign response = resp_q;
    assign time_out = time_out_q;

endmodule
